data_bridge: RTL and testbench
==============================

DATA_BRIDGE -- requirements
Module: data_bridge

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, byte address width on both the CPU side and the bus side.
REQ-002 SHALL have parameter DATA_W, default 32, data width on both sides; only 32 is supported.
REQ-003 SHALL have port clk, input, 1, the single clock for the whole block.
REQ-004 SHALL have port rst, input, 1; reset is asynchronous and active-high.
REQ-005 SHALL have CPU-side ports:
- data_en  input  1  CPU access request (MEM stage).
- data_wen  input  4  byte write enables; 0 means read.
- data_addr  input  ADDR_W  byte address.
- data_wdata  input  DATA_W  store data, already lane-aligned.
- data_rdata  output  DATA_W  load data.
- flush  input  1  exception flush from CP0.
REQ-006 SHALL have port stall_o, output, 1, which holds the pipeline until the access completes.
REQ-007 SHALL have bus-side ports:
- bus_req  output  1  request valid.
- bus_wr  output  1  1 for write.
- bus_size  output  2  0 = byte, 1 = half, 2 = word.
- bus_wstrb  output  4  byte strobes.
- bus_addr  output  ADDR_W  request address.
- bus_wdata  output  DATA_W  write data.
- bus_addr_ok  input  1  request accepted.
- bus_data_ok  input  1  response valid.
- bus_rdata  input  DATA_W  response data.
REQ-008 SHALL have port stall_cycles, output, 16, a saturating count of cycles with stall_o high.

Function
REQ-009 SHALL implement four states: IDLE, REQ, WAIT, DONE.
REQ-010 In IDLE with data_en=1 and flush=0, SHALL register addr, wen and wdata, go to REQ, and assert stall_o combinationally in that same cycle.
REQ-011 In REQ, SHALL drive bus_req=1 from the registered values, holding them stable until bus_addr_ok; on bus_addr_ok it SHALL go to WAIT.
REQ-012 In WAIT, SHALL keep bus_req=0; on bus_data_ok it SHALL register bus_rdata (reads only) and go to DONE.
REQ-013 In DONE, SHALL deassert stall_o, present the registered read data on data_rdata, and return to IDLE the next cycle. DONE ignores data_en.
REQ-014 bus_addr_ok and bus_data_ok arriving in the same cycle while in REQ SHALL move the FSM directly to DONE, capturing data.
REQ-015 Minimum latency SHALL be 3 cycles: data_en at cycle 0, bus_req at cycle 1, DONE at cycle 2 with a combined ok, stall released at cycle 2.
REQ-016 stall_o SHALL be high in REQ and WAIT, and in IDLE when data_en=1 and flush=0; it SHALL be low otherwise.
REQ-017 bus_wr SHALL equal (wen != 0).
REQ-018 bus_size SHALL be derived from wen:
- 0001/0010/0100/1000 give 0.
- 0011/1100 give 1.
- 1111 gives 2.
- A read (wen=0) gives 2.
REQ-019 On reads, bus_wstrb SHALL be 0.
REQ-020 Any other wen pattern SHALL be issued as a word write with bus_wstrb equal to wen.
REQ-021 flush in IDLE SHALL suppress the new access.
REQ-022 flush in REQ before bus_addr_ok SHALL drop the request and return to IDLE next cycle.
REQ-023 flush in REQ coinciding with bus_addr_ok, or flush in WAIT, SHALL set a discard flag.
REQ-024 With the discard flag set, the FSM SHALL stay in WAIT until bus_data_ok, then go to IDLE without updating data_rdata. stall_o SHALL stay low while draining.
REQ-025 At most one transaction SHALL be outstanding on the bus at any time.
REQ-026 stall_cycles SHALL increment on every stall_o=1 cycle and saturate at 16'hFFFF.
REQ-027 bus_data_ok received in IDLE or REQ without an outstanding transaction SHALL be ignored.

Reset
REQ-028 Reset SHALL set: state=IDLE, bus_req=0, bus_wr=0, bus_size=2, bus_wstrb=0, bus_addr=0, bus_wdata=0, data_rdata=0, stall_o=0, stall_cycles=0, discard=0.
REQ-029 Reset asserted mid-transaction SHALL abandon it immediately; the bus agent is reset by the same rst.

Structure
REQ-030 The state enum and the SIZE_BYTE/SIZE_HALF/SIZE_WORD constants SHALL live in the shared CPU package.
REQ-031 SHALL use one sub-module, wen_decode (wen to bus_size/bus_wstrb), which is combinational; everything else is inline.

Verification
REQ-032 Read with zero-wait bus: data_en=1, wen=0, addr=0x80001004; combined ok at cycle 1 with rdata=0xDEADBEEF -> data_rdata=0xDEADBEEF and stall_o low at cycle 2.
REQ-033 Byte store: wen=0100, addr=0x10, wdata=0x00AB0000 -> bus_wr=1, bus_size=0, bus_wstrb=0100, bus_addr=0x10.
REQ-034 addr_ok delayed 4 cycles and data_ok 3 cycles later -> bus_req high exactly 5 cycles, stall_o high 9 cycles, stall_cycles=9.
REQ-035 flush in WAIT, then data_ok with rdata=0x1234 -> data_rdata keeps its previous value, FSM returns to IDLE, and no second bus_req is issued.
REQ-036 rst pulsed while in WAIT -> all outputs equal their reset values within the same cycle (asynchronous reset).

Source files
------------

// File: rtl/data_bridge_pkg.sv
// data_bridge_pkg: shared FSM state type and bus size encodings for the data bridge
package data_bridge_pkg;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_e;
  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;
endpackage

// File: rtl/data_bridge_wen_decode.sv
// wen_decode: maps CPU byte enables to bus transfer size and strobes
module wen_decode
  import data_bridge_pkg::*;
(
  input  logic [3:0] wen,
  output logic [1:0] size,
  output logic [3:0] wstrb
);
  logic one_byte, two_byte;
  assign one_byte = (wen == 4'b0001) | (wen == 4'b0010) | (wen == 4'b0100) | (wen == 4'b1000);
  assign two_byte = (wen == 4'b0011) | (wen == 4'b1100);
  // Reads and irregular patterns both go out as word transfers; wen==0 yields zero strobes
  assign size  = one_byte ? SIZE_BYTE : two_byte ? SIZE_HALF : SIZE_WORD;
  assign wstrb = wen;
endmodule

// File: rtl/data_bridge.sv
// data_bridge: single-outstanding CPU MEM-stage to request/response bus bridge
module data_bridge
  import data_bridge_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              data_en,
  input  logic [3:0]        data_wen,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic [DATA_W-1:0] data_rdata,
  input  logic              flush,
  output logic              stall_o,
  output logic              bus_req,
  output logic              bus_wr,
  output logic [1:0]        bus_size,
  output logic [3:0]        bus_wstrb,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_addr_ok,
  input  logic              bus_data_ok,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic [15:0]       stall_cycles
);
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        wen_q, wen_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic              discard_q, discard_d;
  logic [15:0]       stall_cnt_q, stall_cnt_d;
  logic              take, is_read;
  assign take    = data_en & ~flush;
  assign is_read = (wen_q == 4'b0000);
  // A discarded access is drained silently, so the pipeline is not held for it
  assign stall_o = (state_q == REQ) | ((state_q == WAIT) & ~discard_q) | ((state_q == IDLE) & take);
  assign bus_req    = (state_q == REQ);
  assign bus_wr     = ~is_read;
  assign bus_addr   = addr_q;
  assign bus_wdata  = wdata_q;
  assign data_rdata = rdata_q;
  assign stall_cycles = stall_cnt_q;
  wen_decode u_wen_decode (
    .wen   (wen_q),
    .size  (bus_size),
    .wstrb (bus_wstrb)
  );
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wen_d       = wen_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    discard_d   = discard_q;
    stall_cnt_d = (stall_o && stall_cnt_q != 16'hFFFF) ? stall_cnt_q + 16'd1 : stall_cnt_q;
    case (state_q)
      IDLE: if (take) begin
        state_d = REQ;
        addr_d  = data_addr;
        wen_d   = data_wen;
        wdata_d = data_wdata;
      end
      REQ: if (bus_addr_ok) begin
        state_d   = flush ? (bus_data_ok ? IDLE : WAIT) : (bus_data_ok ? DONE : WAIT);
        discard_d = flush & ~bus_data_ok;
        rdata_d   = (~flush & bus_data_ok & is_read) ? bus_rdata : rdata_q;
      end else if (flush) begin
        state_d = IDLE;
      end
      WAIT: if (bus_data_ok) begin
        state_d   = (discard_q | flush) ? IDLE : DONE;
        discard_d = 1'b0;
        rdata_d   = (~discard_q & ~flush & is_read) ? bus_rdata : rdata_q;
      end else if (flush) begin
        discard_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wen_q       <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      discard_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wen_q       <= wen_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      discard_q   <= discard_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end
endmodule

// File: tb/tb_data_bridge.sv
// tb_data_bridge: randomized transaction-level check of data_bridge against a latency/size model
module tb_data_bridge;
  logic        clk, rst;
  logic        data_en, flush, stall_o;
  logic [3:0]  data_wen;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic        bus_req, bus_wr, bus_addr_ok, bus_data_ok;
  logic [1:0]  bus_size;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [15:0] stall_cycles;
  int vectors = 0, errors = 0;
  int stall_total = 0;
  logic [31:0] prev_rd = '0;
  data_bridge dut (
    .clk(clk), .rst(rst), .data_en(data_en), .data_wen(data_wen), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_rdata(data_rdata), .flush(flush), .stall_o(stall_o),
    .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size), .bus_wstrb(bus_wstrb),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_addr_ok(bus_addr_ok),
    .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata), .stall_cycles(stall_cycles)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [1:0] exp_size(input logic [3:0] w);
    if (w == 4'b0001 || w == 4'b0010 || w == 4'b0100 || w == 4'b1000) return 2'd0;
    if (w == 4'b0011 || w == 4'b1100) return 2'd1;
    return 2'd2;
  endfunction
  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req"}, {31'd0, bus_req}, 0);
    chk({tag, "_ctl"}, {25'd0, bus_wr, bus_size, bus_wstrb}, {25'd0, 1'b0, 2'd2, 4'd0});
    chk({tag, "_addr"}, bus_addr, 0);
    chk({tag, "_wdata"}, bus_wdata, 0);
    chk({tag, "_rdata"}, data_rdata, 0);
    chk({tag, "_stall"}, {31'd0, stall_o}, 0);
    chk({tag, "_scnt"}, {16'd0, stall_cycles}, 0);
  endtask
  // fm: 0 = normal, 1 = flush on first WAIT cycle, 2 = flush on first REQ cycle
  task automatic run_txn(input logic [3:0] wen, input logic [31:0] addr, wdata, rd,
                         input int da, dd, fm);
    int reqs = 0, acc = -1, stalls = 0, c = 0, exp_stalls;
    bit fin = 0;
    logic [31:0] exp_rd;
    exp_rd = (fm == 0 && wen == 4'b0000) ? rd : prev_rd;
    exp_stalls = (fm == 0) ? 2 + da + dd : (fm == 1) ? da + 3 : 2;
    while (!fin && c < 64) begin
      @(negedge clk);
      data_en = (c == 0);
      data_wen = (c == 0) ? wen : 4'($urandom);
      data_addr = (c == 0) ? addr : $urandom;
      data_wdata = (c == 0) ? wdata : $urandom;
      flush = 1'b0; bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = $urandom;
      if (bus_req) begin
        reqs++;
        if (fm == 2 && reqs == 1) flush = 1'b1;
        else if (fm != 2 && reqs == da + 1) begin
          bus_addr_ok = 1'b1; acc = c;
          if (dd == 0) begin bus_data_ok = 1'b1; bus_rdata = rd; end
        end
      end else if (acc >= 0 && dd > 0 && c == acc + dd) begin
        bus_data_ok = 1'b1; bus_rdata = rd;
      end
      if (fm == 1 && acc >= 0 && c == acc + 1) flush = 1'b1;
      #1;
      if (stall_o) stalls++;
      if (c == 0) chk("stall_issue", {31'd0, stall_o}, 1);
      if (bus_req) begin
        chk("bus_addr", bus_addr, addr);
        chk("bus_wdata", bus_wdata, wdata);
        chk("bus_ctl", {25'd0, bus_wr, bus_size, bus_wstrb}, {25'd0, wen != 4'b0000, exp_size(wen), wen});
      end
      if ((fm == 2 && c == 2) || (fm != 2 && acc >= 0 && c == acc + dd + 1)) fin = 1;
      c++;
    end
    if (!fin) chk("timeout", 0, 1);
    stall_total += exp_stalls;
    chk("data_rdata", data_rdata, exp_rd);
    chk("stall_end", {31'd0, stall_o}, 0);
    chk("req_cycles", reqs, (fm == 2) ? 1 : da + 1);
    chk("stall_len", stalls, exp_stalls);
    chk("stall_cycles", {16'd0, stall_cycles}, stall_total > 16'hFFFF ? 32'hFFFF : stall_total);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      data_en = 1'b0; flush = 1'b0; bus_addr_ok = 1'b0; bus_data_ok = 1'b0;
      #1;
      chk("no_reissue", {31'd0, bus_req}, 0);
    end
    prev_rd = exp_rd;
  endtask
  initial begin
    logic [3:0] wens [9];
    wens = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111, 4'b0101};
    rst = 1'b1; data_en = 0; flush = 0; data_wen = 0; data_addr = 0; data_wdata = 0;
    bus_addr_ok = 0; bus_data_ok = 0; bus_rdata = 0;
    repeat (2) @(negedge clk);
    #1 chk_reset_outputs("reset");
    @(negedge clk) rst = 1'b0;
    run_txn(4'b0000, 32'h80001004, 32'h0, 32'hDEADBEEF, 0, 0, 0);
    run_txn(4'b0100, 32'h00000010, 32'h00AB0000, 32'h0, 1, 1, 0);
    run_txn(4'b1111, 32'h00000020, 32'h11223344, 32'h0, 4, 3, 0);
    run_txn(4'b0000, 32'h00000040, 32'h0, 32'h00001234, 0, 2, 1);
    run_txn(4'b0000, 32'h00000044, 32'h0, 32'h55AA55AA, 2, 0, 2);
    for (int n = 0; n < 30; n++) begin
      int da, dd, fm;
      logic [3:0] w;
      w  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : wens[$urandom_range(0, 8)];
      da = $urandom_range(0, 4);
      dd = $urandom_range(0, 4);
      fm = $urandom_range(0, 3);
      if (fm == 3 || (fm == 2 && da == 0) || (fm == 1 && dd == 0)) fm = 0;
      run_txn(w, $urandom, $urandom, $urandom, da, dd, fm);
    end
    @(negedge clk);
    data_en = 1'b1; data_wen = 4'b0000; data_addr = 32'h100; data_wdata = 0;
    @(negedge clk);
    data_en = 1'b0; bus_addr_ok = 1'b1;
    @(negedge clk);
    bus_addr_ok = 1'b0;
    #1 chk("wait_stall", {31'd0, stall_o}, 1);
    #1 rst = 1'b1;
    #1 chk_reset_outputs("async_rst");
    @(negedge clk) rst = 1'b0;
    stall_total = 0; prev_rd = '0;
    run_txn(4'b0000, 32'h200, 32'h0, 32'hCAFEF00D, 1, 1, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
